// File: rtl/id_ex_stage_if.sv
// ID/EX stage signal bundle: decoded ID fields, forwarding sources and EX-side outputs.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_ALUOp;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_Branch;
    logic        stall, flush;
    logic        mem_RegWrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] A, B;
    logic [3:0]  ALU_Control;
    logic [31:0] ex_store_data, ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_Branch;
    logic        load_use_stall;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_ALUOp, id_funct3, id_funct7b5, id_ALUSrc, id_RegWrite, id_MemRead,
               id_MemWrite, id_MemToReg, id_Branch, stall, flush,
               mem_RegWrite, mem_rd, mem_result, wb_RegWrite, wb_rd, wb_result,
        input  A, B, ALU_Control, ex_store_data, ex_pc, ex_rd, ex_valid, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_MemToReg, ex_Branch, load_use_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_ALUOp, id_funct3, id_funct7b5, id_ALUSrc, id_RegWrite, id_MemRead,
               id_MemWrite, id_MemToReg, id_Branch, stall, flush,
               mem_RegWrite, mem_rd, mem_result, wb_RegWrite, wb_rd, wb_result,
        output A, B, ALU_Control, ex_store_data, ex_pc, ex_rd, ex_valid, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_MemToReg, ex_Branch, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM + MEM/WB operand forwarding
// and load-use hazard detection.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    id_ex_stage_if.slave io
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_NONE = 4'b1111
    } alu_ctrl_e;

    alu_ctrl_e   id_alu_ctrl, ex_alu_ctrl;
    logic        ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        load_use;

    always_comb begin
        id_alu_ctrl = ALU_ADD;
        case (io.id_ALUOp)
            2'b00: id_alu_ctrl = ALU_ADD;
            2'b01: id_alu_ctrl = ALU_SUB;
            default: begin
                case (io.id_funct3)
                    3'b000: id_alu_ctrl = (io.id_ALUOp == 2'b10 && io.id_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111: id_alu_ctrl = ALU_AND;
                    3'b110: id_alu_ctrl = ALU_OR;
                    3'b001: id_alu_ctrl = ALU_SLL;
                    3'b101: id_alu_ctrl = ALU_SRL;
                    default: id_alu_ctrl = ALU_NONE;
                endcase
            end
        endcase
    end

    // Conservative: any rs2 match counts, even for instructions that do not read rs2.
    assign load_use = ex_valid && ex_memread && (ex_rd != 5'd0) && io.id_valid &&
                      ((ex_rd == io.id_rs1) || (ex_rd == io.id_rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!io.stall && (io.flush || load_use))) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_ctrl <= ALU_ADD;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (io.flush) begin
            // flush beats stall: bubble even while held
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_ctrl <= ALU_ADD;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (!io.stall) begin
            ex_valid    <= io.id_valid;
            ex_pc       <= io.id_pc;
            ex_rs1_data <= io.id_rs1_data;
            ex_rs2_data <= io.id_rs2_data;
            ex_imm      <= io.id_imm;
            ex_rs1      <= io.id_rs1;
            ex_rs2      <= io.id_rs2;
            ex_rd       <= io.id_rd;
            ex_alu_ctrl <= id_alu_ctrl;
            ex_alusrc   <= io.id_ALUSrc;
            ex_regwrite <= io.id_RegWrite;
            ex_memread  <= io.id_MemRead;
            ex_memwrite <= io.id_MemWrite;
            ex_memtoreg <= io.id_MemToReg;
            ex_branch   <= io.id_Branch;
        end
    end

    always_comb begin
        fwd_rs1 = ex_rs1_data;
        if (io.mem_RegWrite && io.mem_rd != 5'd0 && io.mem_rd == ex_rs1)
            fwd_rs1 = io.mem_result;
        else if (io.wb_RegWrite && io.wb_rd != 5'd0 && io.wb_rd == ex_rs1)
            fwd_rs1 = io.wb_result;
    end

    always_comb begin
        fwd_rs2 = ex_rs2_data;
        if (io.mem_RegWrite && io.mem_rd != 5'd0 && io.mem_rd == ex_rs2)
            fwd_rs2 = io.mem_result;
        else if (io.wb_RegWrite && io.wb_rd != 5'd0 && io.wb_rd == ex_rs2)
            fwd_rs2 = io.wb_result;
    end

    assign io.A              = fwd_rs1;
    assign io.B              = ex_alusrc ? ex_imm : fwd_rs2;
    assign io.ex_store_data  = fwd_rs2;
    assign io.ALU_Control    = ex_alu_ctrl;
    assign io.ex_pc          = ex_pc;
    assign io.ex_rd          = ex_rd;
    assign io.ex_valid       = ex_valid;
    assign io.ex_RegWrite    = ex_regwrite;
    assign io.ex_MemRead     = ex_memread;
    assign io.ex_MemWrite    = ex_memwrite;
    assign io.ex_MemToReg    = ex_memtoreg;
    assign io.ex_Branch      = ex_branch;
    assign io.load_use_stall = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a transaction-level model checked every negedge,
// plus hand-computed literal checks at the scenario points.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if io ();

    id_ex_stage dut (.clk(clk), .rst(rst), .io(io.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7, alusrc, rw, mr, mw, m2r, br;
    } instr_t;

    // Model of what EX currently holds; ctl is the expected ALU code.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctl;
        logic        alusrc, rw, mr, mw, m2r, br;
    } ex_t;

    ex_t m;

    function automatic logic [3:0] exp_ctl(logic [1:0] aluop, logic [2:0] f3, logic f7);
        logic [3:0] tbl [8] = '{4'h0, 4'h4, 4'hF, 4'hF, 4'hF, 4'h5, 4'h3, 4'h2};
        if (aluop == 2'd0) return 4'h0;
        if (aluop == 2'd1) return 4'h1;
        if (f3 == 3'd0 && aluop == 2'd2 && f7) return 4'h1;
        return tbl[f3];
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (io.mem_RegWrite && io.mem_rd == idx) return io.mem_result;
        if (io.wb_RegWrite && io.wb_rd == idx) return io.wb_result;
        return rf;
    endfunction

    function automatic logic model_luse();
        return m.v && m.mr && m.rd != 5'd0 && io.id_valid &&
               (m.rd == io.id_rs1 || m.rd == io.id_rs2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m = '0;
        else if (io.flush) m = '0;
        else if (io.stall) m = m;
        else if (model_luse()) m = '0;
        else begin
            m.v = io.id_valid;       m.pc = io.id_pc;
            m.r1d = io.id_rs1_data;  m.r2d = io.id_rs2_data; m.imm = io.id_imm;
            m.rs1 = io.id_rs1;       m.rs2 = io.id_rs2;      m.rd = io.id_rd;
            m.ctl = exp_ctl(io.id_ALUOp, io.id_funct3, io.id_funct7b5);
            m.alusrc = io.id_ALUSrc; m.rw = io.id_RegWrite;  m.mr = io.id_MemRead;
            m.mw = io.id_MemWrite;   m.m2r = io.id_MemToReg; m.br = io.id_Branch;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_A", io.A, fwd(m.rs1, m.r1d));
        chk("model_B", io.B, m.alusrc ? m.imm : fwd(m.rs2, m.r2d));
        chk("model_store", io.ex_store_data, fwd(m.rs2, m.r2d));
        chk("model_ctl", 32'(io.ALU_Control), 32'(m.ctl));
        chk("model_pc", io.ex_pc, m.pc);
        chk("model_rd", 32'(io.ex_rd), 32'(m.rd));
        chk("model_ctrlbits", 32'({io.ex_valid, io.ex_RegWrite, io.ex_MemRead, io.ex_MemWrite,
                                   io.ex_MemToReg, io.ex_Branch}),
            32'({m.v, m.rw, m.mr, m.mw, m.m2r, m.br}));
        chk("model_luse", 32'(io.load_use_stall), 32'(model_luse()));
    end

    function automatic instr_t mk(logic [31:0] pc, logic [31:0] r1d, logic [31:0] r2d,
                                  logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                  logic [4:0] rd, logic [1:0] aluop, logic [2:0] f3,
                                  logic f7, logic alusrc, logic rw, logic mr, logic mw);
        instr_t i;
        i.v = 1'b1; i.pc = pc; i.r1d = r1d; i.r2d = r2d; i.imm = imm;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.aluop = aluop; i.f3 = f3; i.f7 = f7;
        i.alusrc = alusrc; i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = mr;
        i.br = (aluop == 2'd1);
        return i;
    endfunction

    task automatic drive(input instr_t i);
        io.id_valid = i.v;         io.id_pc = i.pc;
        io.id_rs1_data = i.r1d;    io.id_rs2_data = i.r2d;  io.id_imm = i.imm;
        io.id_rs1 = i.rs1;         io.id_rs2 = i.rs2;       io.id_rd = i.rd;
        io.id_ALUOp = i.aluop;     io.id_funct3 = i.f3;     io.id_funct7b5 = i.f7;
        io.id_ALUSrc = i.alusrc;   io.id_RegWrite = i.rw;   io.id_MemRead = i.mr;
        io.id_MemWrite = i.mw;     io.id_MemToReg = i.m2r;  io.id_Branch = i.br;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic no_fwd();
        io.mem_RegWrite = 1'b0; io.mem_rd = 5'd0; io.mem_result = 32'h0;
        io.wb_RegWrite  = 1'b0; io.wb_rd  = 5'd0; io.wb_result  = 32'h0;
    endtask

    initial begin
        instr_t nop;
        nop = '0;
        drive(nop);
        io.stall = 1'b0;
        io.flush = 1'b0;
        no_fwd();

        step();
        chk("reset_A", io.A, 32'h0);
        chk("reset_ctl", 32'(io.ALU_Control), 32'h0);
        chk("reset_valid", 32'(io.ex_valid), 32'h0);
        rst = 1'b0;

        // R-type SUB then I-type ADD with immediate
        drive(mk(32'h100, 32'd10, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        chk("sub_A", io.A, 32'd10);
        chk("sub_B", io.B, 32'd3);
        chk("sub_ctl", 32'(io.ALU_Control), 32'h1);
        drive(mk(32'h104, 32'd10, 32'd3, 32'd5, 5'd1, 5'd2, 5'd3, 2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step();
        chk("addi_B", io.B, 32'd5);
        chk("addi_ctl", 32'(io.ALU_Control), 32'h0);
        chk("addi_store", io.ex_store_data, 32'd3);

        // Forwarding priority
        drive(mk(32'h108, 32'h11, 32'h22, 32'd0, 5'd5, 5'd6, 5'd8, 2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        io.mem_RegWrite = 1'b1; io.mem_rd = 5'd5; io.mem_result = 32'h55;
        io.wb_RegWrite  = 1'b1; io.wb_rd  = 5'd5; io.wb_result  = 32'h77;
        #1 chk("fwd_mem_A", io.A, 32'h55);
        chk("fwd_none_B", io.B, 32'h22);
        io.mem_RegWrite = 1'b0;
        #1 chk("fwd_wb_A", io.A, 32'h77);
        io.wb_rd = 5'd6;
        #1 chk("fwd_wb_store", io.ex_store_data, 32'h77);
        drive(mk(32'h10C, 32'h99, 32'h33, 32'd0, 5'd0, 5'd0, 5'd9, 2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        io.mem_RegWrite = 1'b1; io.mem_rd = 5'd0; io.mem_result = 32'h55;
        io.wb_RegWrite  = 1'b1; io.wb_rd  = 5'd0;
        #1 chk("fwd_x0_A", io.A, 32'h99);
        step();
        no_fwd();

        // Decode corners
        drive(mk(32'h110, 32'd1, 32'd2, 32'd4, 5'd1, 5'd2, 5'd3, 2'b11, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step();
        chk("srl_ctl", 32'(io.ALU_Control), 32'h5);
        drive(mk(32'h114, 32'd1, 32'd2, 32'd4, 5'd1, 5'd2, 5'd3, 2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        chk("slt_ctl", 32'(io.ALU_Control), 32'hF);
        drive(mk(32'h118, 32'd1, 32'd2, 32'd4, 5'd1, 5'd2, 5'd0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        chk("branch_ctl", 32'(io.ALU_Control), 32'h1);
        for (int unsigned k = 0; k < 16; k++) begin
            drive(mk(32'h200 + 32'(k * 4), 32'(k), 32'(k + 1), 32'(k + 2), 5'd10, 5'd11, 5'd12,
                     (k < 8) ? 2'b10 : 2'b11, 3'(k), k[0], k[1], 1'b1, 1'b0, 1'b0));
            step();
        end

        // Load-use hazard
        drive(mk(32'h120, 32'h40, 32'h0, 32'h8, 5'd2, 5'd0, 5'd7, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        drive(mk(32'h124, 32'h1, 32'h2, 32'h0, 5'd3, 5'd7, 5'd9, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        #1 chk("luse_high", 32'(io.load_use_stall), 32'h1);
        step();
        chk("luse_bubble_valid", 32'(io.ex_valid), 32'h0);
        chk("luse_bubble_rw", 32'(io.ex_RegWrite), 32'h0);
        chk("luse_released", 32'(io.load_use_stall), 32'h0);
        step();
        chk("luse_after_pc", io.ex_pc, 32'h124);

        // Stall together with a hazard: hold wins, hazard persists
        drive(mk(32'h128, 32'h40, 32'h0, 32'h8, 5'd2, 5'd0, 5'd7, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        drive(mk(32'h12C, 32'h1, 32'h2, 32'h0, 5'd7, 5'd4, 5'd9, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        io.stall = 1'b1;
        step();
        chk("stall_luse_hold", 32'(io.load_use_stall), 32'h1);
        chk("stall_luse_pc", io.ex_pc, 32'h128);
        io.stall = 1'b0;
        step();
        chk("stall_luse_bubble", 32'(io.ex_valid), 32'h0);
        step();

        // Stall hold for 3 cycles, then flush+stall
        drive(mk(32'h130, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd3, 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        io.stall = 1'b1;
        drive(mk(32'h134, 32'hD, 32'hE, 32'hF, 5'd4, 5'd5, 5'd6, 2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", io.ex_pc, 32'h130);
            chk("stall_ctl", 32'(io.ALU_Control), 32'h4);
        end
        io.flush = 1'b1;
        step();
        chk("flush_stall_valid", 32'(io.ex_valid), 32'h0);
        io.flush = 1'b0;
        io.stall = 1'b0;

        // Async reset while stalled
        step();
        chk("pre_rst_valid", 32'(io.ex_valid), 32'h1);
        io.stall = 1'b1;
        #1 rst = 1'b1;
        #1 chk("arst_A", io.A, 32'h0);
        chk("arst_B", io.B, 32'h0);
        chk("arst_ctl", 32'(io.ALU_Control), 32'h0);
        chk("arst_valid", 32'(io.ex_valid), 32'h0);
        chk("arst_luse", 32'(io.load_use_stall), 32'h0);
        step();
        rst = 1'b0;
        io.stall = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
